// File: rtl/seq_mult_pkg.sv
// Shared definitions for the parametrised shift-add multiplier.
//   state_t       : controller state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : operand width used when WIDTH is not overridden
// Optional feature macro: SIGNED_MULT_EN (two's-complement operands).
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_mult_ctrl_param_if.sv
// Handshake/operand bundle between the top-level sequencer and the multiplier.
//   start   : operation request (master -> slave)
//   a, b    : WIDTH-bit operands (master -> slave)
//   busy    : multiplier iterating (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   product : 2*WIDTH-bit result register (slave -> master)
// Optional feature macro: SIGNED_MULT_EN (no effect on the bundle itself).
interface seq_mult_ctrl_param_if #(
    parameter int WIDTH = seq_mult_pkg::DEFAULT_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_fsm.sv
// Controller for the shift-add multiplier: state register, iteration counter
// and datapath strobes.
//   clk, rst : clock, synchronous active-high reset
//   start    : operation request, honoured in IDLE and DONE only
//   a_lsb    : current LSB of the multiplier register
//   load     : capture operands and clear the accumulator
//   shift    : perform one add/shift iteration
//   add_en   : add multiplicand this iteration
//   sub_en   : subtract multiplicand this iteration (SIGNED_MULT_EN only)
//   last     : this is the final iteration
//   busy     : high while in SHIFT
//   done     : high for the single DONE cycle
// Optional feature macro: SIGNED_MULT_EN.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | iterating, WIDTH cycles
// DONE  | result just registered; start here re-triggers back-to-back
module seq_mult_fsm
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_lsb,
    output logic load,
    output logic shift,
    output logic add_en,
`ifdef SIGNED_MULT_EN
    output logic sub_en,
`endif
    output logic last,
    output logic busy,
    output logic done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load)
                cnt_q <= '0;
            else if (shift)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last)
                    state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SIGNED_MULT_EN
    // The final iteration weighs the multiplier's sign bit negatively.
    assign add_en = shift && a_lsb && !last;
    assign sub_en = shift && a_lsb && last;
`else
    assign add_en = shift && a_lsb;
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: rtl/seq_mult_ctrl_param.sv
// Parametrised shift-add sequential multiplier with start/busy/done handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seq_mult_ctrl_param_if (start, a, b, busy,
//              done, product)
// Result latency is WIDTH+1 cycles from the accept edge; start held high
// re-triggers from the DONE cycle with no idle gap.
// Optional feature macro: SIGNED_MULT_EN (two's-complement operands/result).
module seq_mult_ctrl_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_mult_ctrl_param_if.slave  bus
);

    logic load, shift, add_en, last, busy, done;
`ifdef SIGNED_MULT_EN
    logic sub_en;
`endif

    logic [WIDTH-1:0]   a_q, b_q, p_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH:0]     p_ext, b_ext, sum;
    logic [WIDTH-1:0]   p_nxt, a_nxt;

    seq_mult_fsm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.start),
        .a_lsb  (a_q[0]),
        .load   (load),
        .shift  (shift),
        .add_en (add_en),
`ifdef SIGNED_MULT_EN
        .sub_en (sub_en),
`endif
        .last   (last),
        .busy   (busy),
        .done   (done)
    );

    // Upper sum is one bit wider than P so the carry (or sign) survives the
    // shift into P's MSB.
`ifdef SIGNED_MULT_EN
    assign p_ext = {p_q[WIDTH-1], p_q};
    assign b_ext = {b_q[WIDTH-1], b_q};
`else
    assign p_ext = {1'b0, p_q};
    assign b_ext = {1'b0, b_q};
`endif

    always_comb begin
        sum = p_ext;
        if (add_en)
            sum = p_ext + b_ext;
`ifdef SIGNED_MULT_EN
        else if (sub_en)
            sum = p_ext - b_ext;
`endif
    end

    assign p_nxt = sum[WIDTH:1];
    assign a_nxt = {sum[0], a_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else if (load) begin
            a_q <= bus.a;
            b_q <= bus.b;
            p_q <= '0;
        end else if (shift) begin
            p_q <= p_nxt;
            a_q <= a_nxt;
            if (last)
                product_q <= {p_nxt, a_nxt};
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl_param.sv
// Self-checking bench for seq_mult_ctrl_param: WIDTH=8 and WIDTH=4 instances.
// Expected products follow SIGNED_MULT_EN when the macro is defined.
module tb_seq_mult_ctrl_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_mult_ctrl_param_if #(.WIDTH(8)) bus8 ();
    seq_mult_ctrl_param_if #(.WIDTH(4)) bus4 ();

    seq_mult_ctrl_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    seq_mult_ctrl_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer multiplication of the operands.
    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        logic [15:0] ua, ub;
`ifdef SIGNED_MULT_EN
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        return 16'(sa * sb);
`else
        ua = {8'd0, a};
        ub = {8'd0, b};
        return 16'(ua * ub);
`endif
    endfunction

    task automatic run_op8(input string nm, input logic [7:0] a_in,
                           input logic [7:0] b_in, input logic [15:0] exp);
        int nb, nd;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a_in;
        bus8.b     = b_in;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.busy) nb++;
            if (bus8.done) nd++;
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, nb, 8);
        chk({nm, "_early_done"}, nd, 0);
        chk({nm, "_done"}, {31'd0, bus8.done}, 1);
        chk({nm, "_busy_at_done"}, {31'd0, bus8.busy}, 0);
        chk({nm, "_product"}, {16'd0, bus8.product}, {16'd0, exp});
    endtask

    initial begin
        int d1, d2, nb, nd;
        logic [7:0] ra, rb;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
`ifdef SIGNED_MULT_EN
        vecs[1] = '{8'd255, 8'd255, 16'h0001};
        vecs[3] = '{8'hFD,  8'd5,   16'hFFF1};
        vecs[4] = '{8'h80,  8'h80,  16'h4000};
        vecs[5] = '{8'h7F,  8'h80,  16'hC080};
`else
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[3] = '{8'hFD,  8'd5,   16'h04F1};
        vecs[4] = '{8'h80,  8'h80,  16'h4000};
        vecs[5] = '{8'h7F,  8'h80,  16'h3F80};
`endif

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus8.busy}, 0);
        chk("rst_done", {31'd0, bus8.done}, 0);
        chk("rst_product", {16'd0, bus8.product}, 0);
        chk("rst_product4", {24'd0, bus4.product}, 0);

        for (int i = 0; i < 6; i++)
            run_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

        // Back-to-back with start held high, new operands in the DONE cycle
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd3; bus8.b = 8'd7;
        d1 = -1; d2 = -1; nb = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (bus8.done) begin
                if (d1 < 0) d1 = k; else d2 = k;
            end
            if (bus8.busy) nb++;
            if (k == 9) begin
                chk("b2b_product1", {16'd0, bus8.product}, 21);
                bus8.a = 8'd5; bus8.b = 8'd5;
            end
            if (k == 18) begin
                chk("b2b_product2", {16'd0, bus8.product}, 25);
                bus8.start = 1'b0;
            end
        end
        chk("b2b_done1_cycle", d1, 9);
        chk("b2b_done2_cycle", d2, 18);
        chk("b2b_busy_cycles", nb, 16);

        // start pulsed mid-SHIFT with new operands is ignored
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd13; bus8.b = 8'd11;
        nd = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k < 9 && bus8.done) nd++;
            if (k == 1) bus8.start = 1'b0;
            if (k == 3) begin bus8.start = 1'b1; bus8.a = 8'd99; bus8.b = 8'd99; end
            if (k == 4) bus8.start = 1'b0;
        end
        chk("mid_early_done", nd, 0);
        chk("mid_done", {31'd0, bus8.done}, 1);
        chk("mid_product", {16'd0, bus8.product}, 143);

        // Reset in the 4th SHIFT cycle aborts with no done pulse
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd3;
        nd = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                chk("abort_busy", {31'd0, bus8.busy}, 0);
                chk("abort_done", {31'd0, bus8.done}, 0);
                chk("abort_product", {16'd0, bus8.product}, 0);
                rst = 1'b0;
            end
            if (k > 5 && bus8.done) nd++;
        end
        chk("abort_no_done", nd, 0);

        // WIDTH=4 instance: 15 x 15
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'd15; bus4.b = 4'd15;
        nb = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) bus4.start = 1'b0;
            if (k < 5 && bus4.busy) nb++;
        end
        chk("w4_busy_cycles", nb, 4);
        chk("w4_done", {31'd0, bus4.done}, 1);
`ifdef SIGNED_MULT_EN
        chk("w4_product", {24'd0, bus4.product}, 32'h01);
`else
        chk("w4_product", {24'd0, bus4.product}, 32'hE1);
`endif

        // Random operands against the arithmetic reference
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op8($sformatf("rnd%0d", r), ra, rb, ref8(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_mult_ctrl_param.md
Name: seq_mult_ctrl_param

Overview:
Parametrised shift-add sequential multiplier: controller FSM, iteration counter and datapath in one block.
- Successor to the fixed 8-bit multiplier controller.
- Generalised to WIDTH-bit operands; adds a start/busy/done handshake, back-to-back operation and an optional signed mode.
- Sits beside the ALU as a multi-cycle arithmetic unit driven by the top-level sequencer.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
a  input  WIDTH  multiplier operand; captured on the accept edge.
b  input  WIDTH  multiplicand operand; captured on the accept edge.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; product valid from this cycle onward.
product  output  2*WIDTH  result register; holds until the next accept.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, counter=0, internal A/B/P=0.
  - product=0, busy=0, done=0.
  - rst has priority over all other inputs, including mid-operation; an aborted operation produces no done pulse.
- States:
  - IDLE: start=1 accepts the operation.
  - SHIFT: executes WIDTH iterations.
  - DONE: one cycle; done=1.
  - Encoding lives in the package.
- Accept edge (state is IDLE or DONE and start=1):
  - A<=a, B<=b, P<=0, counter<=0, next state SHIFT.
- SHIFT, each cycle:
  - If A[0]=1, upper sum = P + B, computed WIDTH+1 bits wide (carry kept); else upper sum = P.
  - {P,A} <= {upper sum, A} >> 1, with the carry entering P's MSB.
  - counter <= counter+1.
  - When counter==WIDTH-1 this cycle, next state is DONE.
- Leaving SHIFT: product <= {P,A} after the final shift (registered on the SHIFT->DONE edge).
- DONE:
  - done=1, busy=0.
  - start=1 is accepted (back-to-back); otherwise next state is IDLE.
- start is ignored in SHIFT; no queuing. a/b changes after the accept edge have no effect.
- Latency: accept at edge t0 -> busy=1 during cycles t0+1..t0+WIDTH -> done=1 during cycle t0+WIDTH+1. Total WIDTH+1 cycles.
- Throughput: one result per WIDTH+1 cycles when start is held high.
- start held high in IDLE or DONE re-triggers; it is level-sensitive, not edge-detected.
- Wrap-around: none possible; an unsigned product always fits in 2*WIDTH bits.
- product is never updated except on the SHIFT->DONE edge and on reset.

Optional Feature:
SIGNED_MULT_EN
- Defined: operands are two's complement.
  - Upper sum is sign-extended to WIDTH+1 bits; the right shift of P is arithmetic.
  - On the last iteration (counter==WIDTH-1), if A[0]=1, B is subtracted from P instead of added.
  - product is the signed 2*WIDTH-bit result. Latency is unchanged.
- Undefined: unsigned behaviour exactly as above; no subtract path is synthesised.

Decomposition:
Package seq_mult_pkg:
- state enum {IDLE, SHIFT, DONE} (2 bits).
- Localparam for default WIDTH.

Natural sub-module seq_mult_fsm:
- Contains state register, counter and control strobes (load, shift, add_en, sub_en, done).
- Top level holds the A/B/P datapath and the product register.

Test Plan:
- WIDTH=8: rst 2 cycles, then a=13, b=11, start 1 cycle -> busy high 8 cycles, done pulse at cycle 9 after accept, product=143 (0x008F).
- WIDTH=8: a=255, b=255 -> product=65025 (0xFE01); a=0, b=200 -> product=0 with done at the same latency.
- Back-to-back: start held high, a=3, b=7, then a=5, b=5 presented in the DONE cycle -> products 21 then 25, done pulses 9 cycles apart, no IDLE cycle in between.
- Robustness:
  - start pulsed mid-SHIFT with new a/b -> ignored; original result delivered.
  - rst asserted at 4th SHIFT cycle -> next cycle busy=0, done=0, product=0; no done pulse follows.
- WIDTH=4 instance: a=15, b=15 -> product=225 (0xE1) after 5 cycles.
- SIGNED_MULT_EN, WIDTH=8:
  - a=-3 (0xFD), b=5 -> product=0xFFF1 (-15).
  - a=-128, b=-128 -> product=0x4000.
